// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-back to read forwarding.
module regfile_scoreboard #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_ready,
    input  logic                flush,
    output logic [AW:0]         pend_cnt,
    output logic                idle
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] wb_hit;
    logic [NREG-1:0] claim_vec;
    logic [NREG-1:0] busy_nxt;
    logic [AW:0]     cnt_nxt;
    logic            claim;

    // Writes to x0 never count as hits, so x0 can never be busy or written.
    always_comb begin
        wb_hit = '0;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && wr_addr[p*AW +: AW] != '0) begin
                wb_hit[wr_addr[p*AW +: AW]] = 1'b1;
            end
        end
    end

    assign iss_ready = !busy[iss_rd] || wb_hit[iss_rd];
    assign claim     = iss_valid && iss_ready && (iss_rd != '0) && !flush;

    always_comb begin
        claim_vec = '0;
        if (claim) begin
            claim_vec[iss_rd] = 1'b1;
        end
    end

    // A same-address claim re-sets the bit that the write-back clears.
    assign busy_nxt = flush ? '0 : ((busy & ~wb_hit) | claim_vec);

    always_comb begin
        cnt_nxt = '0;
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[r]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] && wr_addr[p*AW +: AW] != '0) begin
                    regs[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
                end
            end
            busy     <= busy_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    assign idle = (pend_cnt == '0);

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            b;

        assign a = rd_addr[i*AW +: AW];

        always_comb begin
            d = (a == '0) ? '0 : regs[a];
            b = busy[a];
`ifdef REGFILE_BYPASS_EN
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] && a != '0 && wr_addr[p*AW +: AW] == a) begin
                    d = wr_data[p*XLEN +: XLEN];
                    b = claim_vec[a];
                end
            end
`endif
        end

        assign rd_data[i*XLEN +: XLEN] = d;
        assign rd_busy[i]              = b;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed plus randomized bench for regfile_scoreboard.
// Reference model: plain arrays of register values and busy flags.
module tb_regfile_scoreboard;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                iss_ready;
    logic                flush;
    logic [AW:0]         pend_cnt;
    logic                idle;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [63:0] m_reg  [NREG];
    bit          m_busy [NREG];

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .AW(AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_valid(iss_valid),
        .iss_rd   (iss_rd),
        .iss_ready(iss_ready),
        .flush    (flush),
        .pend_cnt (pend_cnt),
        .idle     (idle)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int r = 0; r < NREG; r++) if (m_busy[r]) c++;
        return c;
    endfunction

    function automatic bit wb_to(input int a);
        for (int p = 0; p < NWR; p++)
            if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ready();
        return !m_busy[iss_rd] || wb_to(int'(iss_rd));
    endfunction

    task automatic m_reset();
        for (int r = 0; r < NREG; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    task automatic m_update(input bit rdy);
        for (int p = 0; p < NWR; p++)
            if (wr_en[p] && wr_addr[p*AW +: AW] != 0)
                m_reg[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
        for (int p = 0; p < NWR; p++)
            if (wr_en[p]) m_busy[wr_addr[p*AW +: AW]] = 1'b0;
        if (iss_valid && rdy && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        if (flush) for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
        m_busy[0] = 1'b0;
    endtask

    task automatic clr();
        rd_addr   = '0;
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        flush     = 1'b0;
    endtask

    task automatic set_wr(input int p, input int a, input logic [63:0] d);
        wr_en[p]              = 1'b1;
        wr_addr[p*AW +: AW]   = AW'(a);
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic claim(input int a);
        iss_valid = 1'b1;
        iss_rd    = AW'(a);
    endtask

    // Check combinational outputs, clock once, check registered outputs.
    task automatic cycle();
        bit          rdy;
        int          a;
        logic [63:0] ed;
        bit          eb;
        #1;
        rdy = m_ready();
        chk("iss_ready", iss_ready, rdy);
        for (int i = 0; i < NRD; i++) begin
            a  = int'(rd_addr[i*AW +: AW]);
            ed = (a == 0) ? 64'd0 : m_reg[a];
            eb = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
            for (int p = 0; p < NWR; p++) begin
                if (a != 0 && wr_en[p] && int'(wr_addr[p*AW +: AW]) == a) begin
                    ed = wr_data[p*XLEN +: XLEN];
                    eb = iss_valid && rdy && !flush && int'(iss_rd) == a;
                end
            end
`endif
            chk($sformatf("rd_data%0d", i), rd_data[i*XLEN +: XLEN], ed);
            chk($sformatf("rd_busy%0d", i), rd_busy[i], eb);
        end
        @(posedge clk);
        m_update(rdy);
        #1;
        chk("pend_cnt", pend_cnt, m_count());
        chk("idle", idle, m_count() == 0);
    endtask

    initial begin
        rst = 1'b1;
        clr();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_pend", pend_cnt, 0);
        chk("rst_idle", idle, 1);
        chk("rst_ready", iss_ready, 1);
        chk("rst_busy", rd_busy, 0);
        chk("rst_data", rd_data[63:0], 0);

        // Claim x7, then retire it.
        claim(7);
        rd_addr = {5'd7, 5'd7};
        cycle();
        clr();
        rd_addr[4:0] = 5'd7;
        #1;
        chk("t2_busy", rd_busy[0], 1);
        chk("t2_cnt", pend_cnt, 1);
        set_wr(0, 7, 64'hDEAD_BEEF);
        cycle();
        clr();
        rd_addr[4:0] = 5'd7;
        #1;
        chk("t2_data", rd_data[63:0], 64'hDEAD_BEEF);
        chk("t2_free", rd_busy[0], 0);
        chk("t2_idle", idle, 1);

        // WAW stall, then claim coinciding with write-back.
        claim(3);
        cycle();
        clr();
        claim(3);
        #1;
        chk("t3_stall", iss_ready, 0);
        cycle();
        chk("t3_cnt_a", pend_cnt, 1);
        clr();
        claim(3);
        set_wr(1, 3, 64'h33);
        #1;
        chk("t3_ok", iss_ready, 1);
        cycle();
        chk("t3_cnt_b", pend_cnt, 1);
        clr();
        rd_addr[4:0] = 5'd3;
        #1;
        chk("t3_busy", rd_busy[0], 1);
        set_wr(0, 3, 64'h44);
        cycle();

        // Two ports write the same register; port 1 wins.
        clr();
        set_wr(0, 9, 64'h11);
        set_wr(1, 9, 64'h22);
        rd_addr[4:0] = 5'd9;
`ifdef REGFILE_BYPASS_EN
        #1;
        chk("t4_fwd", rd_data[63:0], 64'h22);
`endif
        cycle();
        clr();
        rd_addr[4:0] = 5'd9;
        #1;
        chk("t4_data", rd_data[63:0], 64'h22);

        // x0 is neither writable nor claimable.
        clr();
        set_wr(0, 0, 64'hFF);
        claim(0);
        cycle();
        clr();
        #1;
        chk("t5_data", rd_data[63:0], 0);
        chk("t5_busy", rd_busy[0], 0);
        chk("t5_cnt", pend_cnt, 0);

        // Flush with claim and write-back in the same cycle.
        claim(2);
        cycle();
        claim(4);
        cycle();
        claim(6);
        cycle();
        chk("t6_pre", pend_cnt, 3);
        clr();
        flush = 1'b1;
        claim(8);
        set_wr(0, 4, 64'd5);
        cycle();
        clr();
        rd_addr = {5'd8, 5'd4};
        #1;
        chk("t6_cnt", pend_cnt, 0);
        chk("t6_data", rd_data[63:0], 64'd5);
        chk("t6_busy", rd_busy, 0);
        cycle();

        // Randomized traffic on a small address window.
        repeat (400) begin
            clr();
            rd_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wr_en     = 2'($urandom_range(0, 3));
            wr_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wr_data   = {$urandom, $urandom, $urandom, $urandom};
            iss_valid = 1'($urandom_range(0, 1));
            iss_rd    = 5'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 15) == 0);
            cycle();
        end

        // Asynchronous reset in mid-cycle with a pending write.
        clr();
        claim(5);
        set_wr(0, 5, 64'h1234);
        cycle();
        clr();
        rd_addr = {5'd5, 5'd5};
        #1;
        chk("t1_pre", rd_busy[0], 1);
        #1;
        rst = 1'b1;
        #1;
        chk("t1_data0", rd_data[63:0], 0);
        chk("t1_data1", rd_data[127:64], 0);
        chk("t1_busy", rd_busy, 0);
        chk("t1_cnt", pend_cnt, 0);
        chk("t1_idle", idle, 1);
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the single-write-port integer register file, for the pipelined core. It provides NRD combinational read ports and NWR write-back ports. A per-register busy scoreboard tracks in-flight destination writes, so the issue stage can detect RAW and WAW hazards. A pending-write counter and a flush input support draining the pipeline and recovering from a mispredict.

Parameters:
XLEN, 64, data width of each register
NREG, 32, number of architectural registers (power of 2, >=2); register 0 is hardwired zero
NRD, 2, number of read ports
NWR, 2, number of write-back ports (higher index = younger producer)
AW, $clog2(NREG), register address width (derived)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
rd_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
rd_busy  out  NRD  register addressed by read port i has a pending write
wr_en  in  NWR  write-back enable per port
wr_addr  in  NWR*AW  write-back destination per port
wr_data  in  NWR*XLEN  write-back data per port
iss_valid  in  1  issue stage claims a destination register
iss_rd  in  AW  destination being claimed
iss_ready  out  1  claim accepted this cycle (no WAW hazard)
flush  in  1  synchronous clear of all busy bits; register data retained
pend_cnt  out  AW+1  number of registers currently busy
idle  out  1  pend_cnt == 0

Behaviour:
- Reset (async, rst=1): all registers 0, all busy bits 0, pend_cnt=0. Consequently idle=1, iss_ready=1, rd_busy=0, rd_data=0. Reset asserted mid-operation discards pending writes and claims immediately.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes to address 0 are dropped.
  - Claims of address 0 are accepted (iss_ready=1) but set nothing.
- Write-back: at posedge, each port with wr_en=1 and wr_addr!=0 writes its data. If several ports target the same address, the highest-index port wins.
- Busy clear: a write-back to address a clears busy[a] at the same edge.
- Claim: iss_valid & iss_ready & iss_rd!=0 sets busy[iss_rd] at the next edge.
  - If a claim and a write-back hit the same address in the same cycle, the set wins and busy stays 1 (the newer producer).
- iss_ready is combinational: iss_ready = !busy[iss_rd] | (any write-back to iss_rd this cycle). A claim with iss_ready=0 is ignored and has no side effects.
- Flush: at posedge, all busy bits and pend_cnt go to 0.
  - Write-backs in the same cycle still update data.
  - A claim in the same cycle is discarded; flush wins.
- pend_cnt: registered. Each cycle it changes by +1 for an accepted nonzero claim, and by -1 for each distinct busy address cleared by write-back without a same-address claim. It never exceeds NREG-1 and never underflows.
- A write-back to a non-busy register is legal: data is written and the counter is unchanged.
- Read path: rd_data and rd_busy are combinational from the array and busy state. Latency is 0 cycles for stored values; a write becomes visible the cycle after the write edge (unless bypass is enabled).

Optional Feature:
REGFILE_BYPASS_EN
- Defined:
  - rd_data[i] forwards wr_data from the highest-index write port with wr_en=1 and wr_addr==rd_addr[i]!=0 in the same cycle.
  - rd_busy[i] is forced to 0 when such a forward occurs and no accepted claim targets that address this cycle.
  - Write-then-read latency is 0.
- Undefined: no forwarding; rd_data and rd_busy reflect only registered state, giving 1-cycle write-to-read visibility.

Test Plan:
1. Reset: assert rst mid-cycle with busy[5]=1 and x5=0x1234 -> immediately rd_data=0 on all ports, rd_busy=0, pend_cnt=0, idle=1.
2. Claim then retire: claim x7 -> next cycle rd_busy=1 for rd_addr=7, pend_cnt=1. Write back x7=0xDEAD_BEEF -> next cycle rd_data=0xDEADBEEF, rd_busy=0, idle=1.
3. WAW stall: x3 busy, iss_valid with iss_rd=3, no write-back -> iss_ready=0 and pend_cnt stays 1. The same with a write-back to x3 this cycle -> iss_ready=1, busy[3] stays 1, pend_cnt stays 1.
4. Dual write collision: ports 0 and 1 both write x9 with 0x11 and 0x22 -> x9=0x22. With REGFILE_BYPASS_EN defined, rd_addr0=9 reads 0x22 in the same cycle.
5. x0: write x0=0xFF and claim x0 -> rd_data for address 0 is 0, rd_busy=0, pend_cnt unchanged.
6. Flush: x2, x4, x6 busy (pend_cnt=3); flush together with a claim of x8 and a write-back x4=5 -> next cycle pend_cnt=0, no registers busy, x4=5.
